// File: rtl/mc_ctrl_pkg.sv
// Shared types and opcode constants for the multicycle core sequencer.
package mc_ctrl_pkg;

  // Sequencer states; encodings are visible on state_o.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd7
  } state_t;

  // Coarse instruction class; all the sequencer needs to pick a path.
  typedef enum logic [2:0] {
    OpAlu,
    OpLoad,
    OpStore,
    OpBranch,
    OpJump,
    OpIllegal
  } op_class_t;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // Classes that retire directly out of EXEC.
  function automatic logic retires_in_exec(op_class_t cls);
    return (cls == OpBranch) || (cls == OpJump);
  endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier for the multicycle sequencer.
module mc_opdecode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // Map the major opcode onto the class that selects the FSM path.
  always_comb begin
    op_class = OpIllegal;
    case (opcode)
      OpcOp, OpcOpImm, OpcLui, OpcAuipc: op_class = OpAlu;
      OpcLoad:                           op_class = OpLoad;
      OpcStore:                          op_class = OpStore;
      OpcBranch:                         op_class = OpBranch;
      OpcJal, OpcJalr:                   op_class = OpJump;
      default:                           op_class = OpIllegal;
    endcase
  end

endmodule

// File: rtl/mc_core_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with bus timeout and error trapping.
module mc_core_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        bus_hready,
  input  logic        bus_hresp,
  output logic        bus_req,
  output logic        bus_write,
  output logic        ir_we,
  output logic        if_en,
  output logic        ex_en,
  output logic        wb_en,
  output logic        trap,
  output logic [2:0]  state_o,
  output logic [31:0] instr_cnt
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
  // Counter value during the last permitted transfer cycle.
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WAIT_LIMIT - 1);

  state_t            state_q, state_d;
  op_class_t         op_class;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              trap_q, trap_d;
  logic [31:0]       instr_cnt_q, instr_cnt_d;
  logic              xfer_done;
  logic              xfer_timeout;
  state_t            retire_next;

  // The IR holds the opcode steady from DECODE until retirement.
  mc_opdecode u_opdecode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // An error response wins over hready; timeout only when neither arrives.
  assign xfer_done    = bus_hready & ~bus_hresp;
  assign xfer_timeout = ~bus_hready & ~bus_hresp & (wait_q == WaitLast);
  assign retire_next  = halt_req ? StIdle : StFetch;

  // State register plus wait counter, sticky trap and retire counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      trap_q      <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      trap_q      <= trap_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (bus_hresp)         state_d = StTrap;
        else if (bus_hready)   state_d = StDecode;
        else if (xfer_timeout) state_d = StTrap;
      end
      StDecode: begin
        state_d = (op_class == OpIllegal) ? StTrap : StExec;
      end
      StExec: begin
        if (retires_in_exec(op_class))                      state_d = retire_next;
        else if (op_class == OpLoad || op_class == OpStore) state_d = StMem;
        else                                                state_d = StWb;
      end
      StMem: begin
        if (bus_hresp)         state_d = StTrap;
        else if (bus_hready)   state_d = (op_class == OpStore) ? retire_next : StWb;
        else if (xfer_timeout) state_d = StTrap;
      end
      StWb: begin
        state_d = retire_next;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
      end
    endcase
  end

  // Decoded strobes; every retire path raises if_en exactly once.
  always_comb begin
    bus_req   = 1'b0;
    bus_write = 1'b0;
    ir_we     = 1'b0;
    if_en     = 1'b0;
    ex_en     = 1'b0;
    wb_en     = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus_req = 1'b1;
        ir_we   = xfer_done;
      end
      StExec: begin
        ex_en = 1'b1;
        if_en = retires_in_exec(op_class);
        // Jumps write the link register here, not in WB.
        wb_en = (op_class == OpJump);
      end
      StMem: begin
        bus_req   = 1'b1;
        bus_write = (op_class == OpStore);
        if_en     = xfer_done & (op_class == OpStore);
      end
      StWb: begin
        wb_en = 1'b1;
        if_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Counter and flag updates; wait count restarts whenever a transfer state is entered.
  always_comb begin
    wait_d      = '0;
    if ((state_q == StFetch || state_q == StMem) && state_d == state_q) begin
      wait_d = wait_q + 1'b1;
    end
    trap_d      = trap_q | (state_d == StTrap);
    instr_cnt_d = instr_cnt_q + 32'(if_en);
  end

  assign state_o   = state_q;
  assign trap      = trap_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Self-checking bench for mc_core_ctrl: a per-instruction trace model builds the
// stimulus and expected outputs for every cycle, and one process replays and compares.
module tb_mc_core_ctrl;

  localparam int WaitLimit = 16;
  localparam int CAlu = 0, CLoad = 1, CStore = 2, CBranch = 3, CJump = 4, CIll = 5;

  logic        clk = 1'b0;
  logic        reset, run, halt_req, bus_hready, bus_hresp;
  logic [6:0]  opcode;
  logic        bus_req, bus_write, ir_we, if_en, ex_en, wb_en, trap;
  logic [2:0]  state_o;
  logic [31:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, run, halt, hready, hresp;
    logic [6:0]  op;
    bit          chk;
    logic [2:0]  st;
    logic        breq, bwr, irwe, ifen, exen, wben, trap;
    logic [31:0] cnt;
  } item_t;

  item_t       q[$];
  logic [31:0] m_cnt;
  logic [6:0]  m_op;

  mc_core_ctrl #(.WAIT_LIMIT(WaitLimit)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .halt_req   (halt_req),
    .opcode     (opcode),
    .bus_hready (bus_hready),
    .bus_hresp  (bus_hresp),
    .bus_req    (bus_req),
    .bus_write  (bus_write),
    .ir_we      (ir_we),
    .if_en      (if_en),
    .ex_en      (ex_en),
    .wb_en      (wb_en),
    .trap       (trap),
    .state_o    (state_o),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic int classify(logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return CAlu;
      7'b0000011:                                     return CLoad;
      7'b0100011:                                     return CStore;
      7'b1100011:                                     return CBranch;
      7'b1101111, 7'b1100111:                         return CJump;
      default:                                        return CIll;
    endcase
  endfunction

  // One cycle in state st with random don't-care inputs and all strobes low.
  function automatic item_t base(logic [2:0] st);
    item_t it;
    it.rst = 1'b1;  it.run = 1'($urandom);  it.halt = 1'($urandom);
    it.hready = 1'($urandom);  it.hresp = 1'($urandom);
    it.op = m_op;  it.chk = 1'b1;  it.st = st;
    it.breq = 0; it.bwr = 0; it.irwe = 0; it.ifen = 0; it.exen = 0; it.wben = 0;
    it.trap = (st == 3'd7);
    it.cnt = m_cnt;
    return it;
  endfunction

  // Bus transfer: waits cycles of hready=0, then completion, unless an error
  // lands at cycle err_at first or the WaitLimit budget runs out.
  task automatic xfer(bit is_mem, bit wr, int waits, int err_at, bit halt, output bit ok);
    item_t it;
    ok = 1'b0;
    for (int c = 1; c <= WaitLimit; c++) begin
      it = base(is_mem ? 3'd4 : 3'd1);
      it.breq = 1'b1;
      it.bwr  = wr;
      if (err_at == c) begin
        it.hresp = 1'b1;
        q.push_back(it);
        return;
      end
      it.hresp = 1'b0;
      if (c == waits + 1) begin
        it.hready = 1'b1;
        it.irwe   = !is_mem;
        it.ifen   = is_mem && wr;
        it.halt   = halt;
        q.push_back(it);
        ok = 1'b1;
        return;
      end
      it.hready = 1'b0;
      q.push_back(it);
    end
  endtask

  task automatic retire(bit halt);
    item_t it;
    int k;
    m_cnt++;
    if (halt) begin
      k = $urandom_range(3, 1);
      for (int i = 0; i < k; i++) begin
        it = base(3'd0);
        it.run = 1'b0;
        q.push_back(it);
      end
      it = base(3'd0);
      it.run = 1'b1;
      q.push_back(it);
    end
  endtask

  task automatic instr(logic [6:0] op, int fw, int fe, int mw, int me, bit halt,
                       output bit trapped);
    item_t it;
    bit ok;
    int cls;
    cls = classify(op);
    m_op = op;
    trapped = 1'b1;
    xfer(1'b0, 1'b0, fw, fe, 1'b0, ok);
    if (!ok) return;
    q.push_back(base(3'd2));
    if (cls == CIll) return;
    it = base(3'd3);
    it.exen = 1'b1;
    if (cls == CBranch || cls == CJump) begin
      it.ifen = 1'b1;
      it.wben = (cls == CJump);
      it.halt = halt;
      q.push_back(it);
      trapped = 1'b0;
      retire(halt);
      return;
    end
    q.push_back(it);
    if (cls == CLoad || cls == CStore) begin
      xfer(1'b1, cls == CStore, mw, me, halt, ok);
      if (!ok) return;
      if (cls == CStore) begin
        trapped = 1'b0;
        retire(halt);
        return;
      end
    end
    it = base(3'd5);
    it.wben = 1'b1;
    it.ifen = 1'b1;
    it.halt = halt;
    q.push_back(it);
    trapped = 1'b0;
    retire(halt);
  endtask

  task automatic trap_hold(int n);
    for (int i = 0; i < n; i++) q.push_back(base(3'd7));
  endtask

  // Two reset cycles then release with run=1, so the next cycle is FETCH.
  task automatic do_reset();
    item_t it;
    it = base(3'd0);
    it.rst = 1'b0;
    it.chk = 1'b0;
    q.push_back(it);
    m_cnt = 0;
    it = base(3'd0);
    it.rst = 1'b0;
    it.run = 1'b1;
    it.hready = 1'b1;
    q.push_back(it);
    it = base(3'd0);
    it.run = 1'b1;
    q.push_back(it);
  endtask

  // Replay the queued trace: drive on negedge, compare 1 ns later.
  task automatic run_q();
    item_t it;
    logic [9:0] got, exp;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      reset = it.rst;  run = it.run;  halt_req = it.halt;
      bus_hready = it.hready;  bus_hresp = it.hresp;  opcode = it.op;
      #1;
      if (it.chk) begin
        got = {state_o, bus_req, bus_write, ir_we, if_en, ex_en, wb_en, trap};
        exp = {it.st, it.breq, it.bwr, it.irwe, it.ifen, it.exen, it.wben, it.trap};
        checks++;
        if (got !== exp || instr_cnt !== it.cnt) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t: got st=%0d req,wr,ir,if,ex,wb,trap=%b cnt=%0d; required st=%0d %b cnt=%0d",
                   $time, got[9:7], got[6:0], instr_cnt, exp[9:7], exp[6:0], it.cnt);
        end
      end
    end
  endtask

  task automatic check_lit(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] legal [9];

  initial begin
    bit tr;
    int n;
    logic [6:0] op;
    legal = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
              7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
    reset = 1'b0; run = 1'b0; halt_req = 1'b0; bus_hready = 1'b0; bus_hresp = 1'b0;
    opcode = 7'h33; m_cnt = 0; m_op = 7'h33;

    do_reset(); run_q(); after_edge();
    check_lit("release_to_fetch", 32'(state_o), 1);

    n = q.size(); instr(7'b0110011, 0, 0, 0, 0, 1'b0, tr);
    check_lit("add_cycles", q.size() - n, 4);
    run_q(); after_edge();
    check_lit("add_cnt", instr_cnt, 1);

    n = q.size(); instr(7'b0000011, 3, 0, 0, 0, 1'b0, tr);
    check_lit("lw_wait3_cycles", q.size() - n, 8);
    run_q(); after_edge();
    check_lit("lw_cnt", instr_cnt, 2);

    n = q.size(); instr(7'b0100011, 0, 0, 0, 0, 1'b0, tr);
    check_lit("sw_cycles", q.size() - n, 4);
    n = q.size(); instr(7'b1100011, 0, 0, 0, 0, 1'b0, tr);
    check_lit("beq_cycles", q.size() - n, 3);
    n = q.size(); instr(7'b1101111, 0, 0, 0, 0, 1'b0, tr);
    check_lit("jal_cycles", q.size() - n, 3);
    run_q(); after_edge();
    check_lit("sw_beq_jal_cnt", instr_cnt, 5);

    instr(7'b0110011, 0, 0, 0, 0, 1'b1, tr);
    run_q(); after_edge();
    check_lit("halt_resume_fetch", 32'(state_o), 1);
    check_lit("halt_cnt", instr_cnt, 6);

    // Fault cases: illegal opcode, fetch error response, fetch timeout.
    for (int f = 0; f < 3; f++) begin
      case (f)
        0:       instr(7'h7F, 0, 0, 0, 0, 1'b0, tr);
        1:       instr(7'b0110011, 0, 1, 0, 0, 1'b0, tr);
        default: instr(7'b0110011, WaitLimit, 0, 0, 0, 1'b0, tr);
      endcase
      check_lit("fault_trapped", 32'(tr), 1);
      trap_hold(10);
      run_q(); after_edge();
      check_lit("fault_state_trap", 32'(state_o), 7);
      check_lit("fault_trap_flag", 32'(trap), 1);
      do_reset(); run_q(); after_edge();
      check_lit("fault_reset_clears", 32'(trap), 0);
      check_lit("fault_reset_cnt", instr_cnt, 0);
    end

    // Reset in the middle of a fetch wait.
    for (int i = 0; i < 2; i++) begin
      item_t it;
      it = base(3'd1);
      it.breq = 1'b1; it.hready = 1'b0; it.hresp = 1'b0;
      q.push_back(it);
    end
    do_reset(); run_q(); after_edge();
    check_lit("mid_xfer_reset", 32'(state_o), 1);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      int fw, fe, mw, me;
      n = $urandom_range(11, 0);
      if (n <= 8) op = legal[n];
      else        op = 7'($urandom);
      fw = ($urandom_range(9, 0) == 0) ? $urandom_range(17, 4) : $urandom_range(2, 0);
      mw = ($urandom_range(9, 0) == 0) ? $urandom_range(17, 4) : $urandom_range(2, 0);
      fe = ($urandom_range(19, 0) == 0) ? $urandom_range(3, 1) : 0;
      me = ($urandom_range(19, 0) == 0) ? $urandom_range(3, 1) : 0;
      instr(op, fw, fe, mw, me, $urandom_range(7, 0) == 0, tr);
      if (tr) begin
        trap_hold($urandom_range(4, 1));
        do_reset();
      end
      run_q();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
